spi_service_packet_receiver: RTL and testbench
==============================================

Name: spi_service_packet_receiver

Overview:
Responder-side parser for the service protocol carried over SPI. It takes the 16-bit word stream produced by the SPI slave deserializer and finds packets addressed to one of two block addresses. It forwards the packet's data words downstream, checks the 16-bit checksum, and reports the command, size, packet number and result. It sits between the SPI slave word interface and the command dispatcher of a milSpi block.

Parameters:
BLOCK_ADDR0, 8'hAB, first accepted address (high byte of the address word)
BLOCK_ADDR1, 8'hAC, second accepted address
TIMEOUT, 16'd2000, idle clocks allowed between words inside a packet before abort

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
in_data  in  16  received SPI word
in_request  in  1  one-cycle strobe, in_data valid
out_data  out  16  forwarded data word
out_valid  out  1  one-cycle strobe, out_data valid
hdr_valid  out  1  one-cycle strobe, addr_sel/cmd/size valid
addr_sel  out  1  0 = BLOCK_ADDR0 matched, 1 = BLOCK_ADDR1 matched
cmd  out  8  command byte
size  out  8  number of data words
pkt_done  out  1  one-cycle strobe, packet finished
pkt_ok  out  1  valid with pkt_done; 1 = checksum matched
pkt_num  out  16  packet-number word, valid with pkt_done
timeout_err  out  1  one-cycle strobe, packet aborted by timeout
busy  out  1  high while not in IDLE

Behaviour:
- Reset (async, nRst=0): all outputs 0, state IDLE, counters and checksum cleared. Asserting reset mid-packet discards the packet with no pkt_done.
- Packet word order: ADDR (addr in [15:8], bits [7:0] ignored), HDR (size in [15:8], cmd in [7:0]), size data words, CHECKSUM, PKTNUM.
- Checksum: 16-bit sum modulo 2^16 of ADDR, HDR and all data words. Examples: AB00,06A2,FFA1,0001,0002,AB45,FFA3,FFA1 -> 5BCF; AC00,0AB0 plus ten 0000 words -> B6B0.
- Escape words (FFA1, FFA3) are ordinary data here: they are counted in size, summed and forwarded unchanged.
- States: IDLE, HDR, DATA, SUM, NUM, SKIP_HDR, SKIP.
  - IDLE: word 0000 is ignored (filler). A word whose high byte equals BLOCK_ADDR0 or BLOCK_ADDR1 latches addr_sel, loads sum = word, goes to HDR. Any other nonzero word goes to SKIP_HDR.
  - HDR: latch size and cmd, add word to sum, pulse hdr_valid the next cycle. Go to DATA, or to SUM if size = 0.
  - DATA: each word pulses out_valid one clock after in_request and is added to sum. After size words, go to SUM.
  - SUM: compare the word against the accumulated sum, latch the result, go to NUM.
  - NUM: latch pkt_num. Next cycle pulse pkt_done with pkt_ok. Go to IDLE.
  - SKIP_HDR: read size; skip count = size + 2. Go to SKIP (wrong-address packets are consumed so their payload is never taken for an address word).
  - SKIP: decrement the count per word; go to IDLE at 0. No outputs are produced.
- Output latency: every output strobe is registered, exactly 1 clock after the causing in_request. Back-to-back in_request on consecutive clocks is supported.
- Timeout: in any non-IDLE state, a counter increments each clock without in_request and clears on in_request.
  - Reaching TIMEOUT: go to IDLE, pulse timeout_err, no pkt_done.
  - in_request in the same cycle the count would expire: the word is accepted and the counter clears.
- size = FF: 8-bit word counter. The skip count is 9 bits (max 257); it must not wrap.

Decomposition:
- Shared package milStd1553 gets:
  - a typedef for the protocol state enum;
  - constants for ADDR/HDR field positions;
  - escape words WSERV_ESC = 16'hFFA1 and DATA_ESC = 16'hFFA3, for the downstream decoder.
- One sub-module, spi_packet_checksum: a 16-bit accumulator with clear, add and compare.

Test Plan:
- Valid packet: AB00,06A2,FFA1,0001,0002,AB45,FFA3,FFA1,5BCF,0000 -> hdr_valid with addr_sel=0, cmd=A2, size=06; six out_valid words FFA1,0001,0002,AB45,FFA3,FFA1; pkt_done with pkt_ok=1, pkt_num=0000.
- Second address, size 10: AC00,0AB0, ten 0000 words, B6B0,0000 -> addr_sel=1, cmd=B0, ten out_valid 0000, pkt_ok=1. Leading 0000 fillers before AC00 are ignored.
- Bad checksum: first packet with 5BCE -> all six data words forwarded, pkt_done with pkt_ok=0.
- Foreign address: AD00,02A2,AB00,06A2,xxxx,0000, then a valid AB00 packet -> no strobes during the AD packet; the following packet parses normally with pkt_ok=1.
- Timeout: AB00,06A2,0001, then silence for TIMEOUT clocks -> timeout_err pulse, busy=0; next AB00 packet parses correctly.
- Reset mid-DATA: nRst low after the third data word -> all outputs 0 immediately; no pkt_done after release.

Source files
------------

// File: rtl/milStd1553_pkg.sv
// Shared definitions for the service protocol carried over SPI: parser states,
// address/header field positions and the escape words used by the downstream decoder.
package milStd1553;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_DATA     = 3'd2,
        ST_SUM      = 3'd3,
        ST_NUM      = 3'd4,
        ST_SKIP_HDR = 3'd5,
        ST_SKIP     = 3'd6
    } pkt_state_t;

    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 8;
    localparam int SIZE_MSB = 15;
    localparam int SIZE_LSB = 8;
    localparam int CMD_MSB  = 7;
    localparam int CMD_LSB  = 0;

    localparam logic [15:0] WSERV_ESC = 16'hFFA1;
    localparam logic [15:0] DATA_ESC  = 16'hFFA3;

endpackage

// File: rtl/spi_packet_checksum.sv
// 16-bit modulo-2^16 running sum. clear together with add loads the word directly,
// so the first word of a packet needs no separate clear cycle.
module spi_packet_checksum (
    input  logic        clk,
    input  logic        nRst,
    input  logic        clear,
    input  logic        add,
    input  logic [15:0] data,
    output logic [15:0] sum,
    output logic        match
);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sum <= 16'h0000;
        end else if (clear && add) begin
            sum <= data;
        end else if (clear) begin
            sum <= 16'h0000;
        end else if (add) begin
            sum <= sum + data;
        end
    end

    assign match = (sum == data);

endmodule

// File: rtl/spi_service_packet_receiver.sv
// Responder-side service packet parser: accepts packets for two block addresses,
// forwards data words, verifies the checksum and reports header/result strobes.
module spi_service_packet_receiver
    import milStd1553::*;
#(
    parameter logic [7:0]  BLOCK_ADDR0 = 8'hAB,
    parameter logic [7:0]  BLOCK_ADDR1 = 8'hAC,
    parameter logic [15:0] TIMEOUT     = 16'd2000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [15:0] in_data,
    input  logic        in_request,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        hdr_valid,
    output logic        addr_sel,
    output logic [7:0]  cmd,
    output logic [7:0]  size,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [15:0] pkt_num,
    output logic        timeout_err,
    output logic        busy
);

    pkt_state_t  state, state_next;
    logic [7:0]  word_cnt, word_cnt_next;
    logic [8:0]  skip_cnt, skip_cnt_next;
    logic [15:0] tmo_cnt, tmo_cnt_next;
    logic        hdr_valid_next, out_valid_next, pkt_done_next, timeout_err_next;
    logic        addr_latch, addr_sel_next, hdr_latch, sum_latch, num_latch;
    logic        sum_clear, sum_add, sum_match, sum_ok;
    logic [15:0] sum_val;
    logic        hit0, hit1;
    logic [7:0]  in_size;

    assign hit0    = (in_data[ADDR_MSB:ADDR_LSB] == BLOCK_ADDR0);
    assign hit1    = (in_data[ADDR_MSB:ADDR_LSB] == BLOCK_ADDR1);
    assign in_size = in_data[SIZE_MSB:SIZE_LSB];
    assign busy    = (state != ST_IDLE);

    spi_packet_checksum u_checksum (
        .clk   (clk),
        .nRst  (nRst),
        .clear (sum_clear),
        .add   (sum_add),
        .data  (in_data),
        .sum   (sum_val),
        .match (sum_match)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next       = state;
        word_cnt_next    = word_cnt;
        skip_cnt_next    = skip_cnt;
        tmo_cnt_next     = 16'h0000;
        hdr_valid_next   = 1'b0;
        out_valid_next   = 1'b0;
        pkt_done_next    = 1'b0;
        timeout_err_next = 1'b0;
        addr_latch       = 1'b0;
        addr_sel_next    = 1'b0;
        hdr_latch        = 1'b0;
        sum_latch        = 1'b0;
        num_latch        = 1'b0;
        sum_clear        = 1'b0;
        sum_add          = 1'b0;

        // A word arriving on the expiring cycle wins over the timeout.
        if (state != ST_IDLE && !in_request) begin
            if (tmo_cnt == TIMEOUT - 16'd1) begin
                state_next       = ST_IDLE;
                timeout_err_next = 1'b1;
            end else begin
                tmo_cnt_next = tmo_cnt + 16'd1;
            end
        end

        if (in_request) begin
            case (state)
                ST_IDLE: begin
                    if (hit0 || hit1) begin
                        addr_latch    = 1'b1;
                        addr_sel_next = !hit0;
                        sum_clear     = 1'b1;
                        sum_add       = 1'b1;
                        state_next    = ST_HDR;
                    end else if (in_data != 16'h0000) begin
                        state_next = ST_SKIP_HDR;
                    end
                end
                ST_HDR: begin
                    hdr_latch      = 1'b1;
                    hdr_valid_next = 1'b1;
                    sum_add        = 1'b1;
                    word_cnt_next  = in_size;
                    state_next     = (in_size == 8'd0) ? ST_SUM : ST_DATA;
                end
                ST_DATA: begin
                    out_valid_next = 1'b1;
                    sum_add        = 1'b1;
                    word_cnt_next  = word_cnt - 8'd1;
                    if (word_cnt == 8'd1) state_next = ST_SUM;
                end
                ST_SUM: begin
                    sum_latch  = 1'b1;
                    state_next = ST_NUM;
                end
                ST_NUM: begin
                    num_latch     = 1'b1;
                    pkt_done_next = 1'b1;
                    state_next    = ST_IDLE;
                end
                ST_SKIP_HDR: begin
                    // data words plus checksum and packet number
                    skip_cnt_next = {1'b0, in_size} + 9'd2;
                    state_next    = ST_SKIP;
                end
                ST_SKIP: begin
                    skip_cnt_next = skip_cnt - 9'd1;
                    if (skip_cnt == 9'd1) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            word_cnt    <= 8'h00;
            skip_cnt    <= 9'h000;
            tmo_cnt     <= 16'h0000;
            out_data    <= 16'h0000;
            out_valid   <= 1'b0;
            hdr_valid   <= 1'b0;
            addr_sel    <= 1'b0;
            cmd         <= 8'h00;
            size        <= 8'h00;
            pkt_done    <= 1'b0;
            pkt_ok      <= 1'b0;
            pkt_num     <= 16'h0000;
            timeout_err <= 1'b0;
            sum_ok      <= 1'b0;
        end else begin
            word_cnt    <= word_cnt_next;
            skip_cnt    <= skip_cnt_next;
            tmo_cnt     <= tmo_cnt_next;
            out_valid   <= out_valid_next;
            hdr_valid   <= hdr_valid_next;
            pkt_done    <= pkt_done_next;
            timeout_err <= timeout_err_next;
            if (out_valid_next) out_data <= in_data;
            if (addr_latch)     addr_sel <= addr_sel_next;
            if (hdr_latch) begin
                size <= in_size;
                cmd  <= in_data[CMD_MSB:CMD_LSB];
            end
            if (sum_latch) sum_ok <= sum_match;
            if (num_latch) begin
                pkt_num <= in_data;
                pkt_ok  <= sum_ok;
            end
        end
    end

endmodule

// File: tb/tb_spi_service_packet_receiver.sv
// Scoreboard bench for spi_service_packet_receiver: expected strobes are queued
// as words are driven and retired by a negedge monitor.
module tb_spi_service_packet_receiver;

    localparam logic [15:0] TIMEOUT = 16'd2000;

    logic        clk = 1'b0;
    logic        nRst;
    logic [15:0] in_data;
    logic        in_request;
    logic [15:0] out_data;
    logic        out_valid, hdr_valid, addr_sel, pkt_done, pkt_ok, timeout_err, busy;
    logic [7:0]  cmd, size;
    logic [15:0] pkt_num;

    spi_service_packet_receiver #(
        .BLOCK_ADDR0 (8'hAB),
        .BLOCK_ADDR1 (8'hAC),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .in_data     (in_data),
        .in_request  (in_request),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .hdr_valid   (hdr_valid),
        .addr_sel    (addr_sel),
        .cmd         (cmd),
        .size        (size),
        .pkt_done    (pkt_done),
        .pkt_ok      (pkt_ok),
        .pkt_num     (pkt_num),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard queues: {cycle, data}, {addr_sel, cmd, size}, {pkt_ok, pkt_num}, cycle
    logic [47:0] exp_out_q[$];
    logic [16:0] exp_hdr_q[$];
    logic [16:0] exp_done_q[$];
    int          exp_tmo_q[$];

    always @(negedge clk) begin
        if (nRst) begin
            if (out_valid) begin
                if (exp_out_q.size() == 0) check("out_unexpected", 64'(exp_out_q.size()), 64'd1);
                else begin
                    logic [47:0] e;
                    e = exp_out_q.pop_front();
                    check("out_data", {48'b0, out_data}, {48'b0, e[15:0]});
                    check("out_latency", 64'(cyc), {32'b0, e[47:16]});
                end
            end
            if (hdr_valid) begin
                if (exp_hdr_q.size() == 0) check("hdr_unexpected", 64'(exp_hdr_q.size()), 64'd1);
                else check("hdr", {47'b0, addr_sel, cmd, size}, {47'b0, exp_hdr_q.pop_front()});
            end
            if (pkt_done) begin
                if (exp_done_q.size() == 0) check("done_unexpected", 64'(exp_done_q.size()), 64'd1);
                else check("done", {47'b0, pkt_ok, pkt_num}, {47'b0, exp_done_q.pop_front()});
            end
            if (timeout_err) begin
                if (exp_tmo_q.size() == 0) check("tmo_unexpected", 64'(exp_tmo_q.size()), 64'd1);
                else check("tmo_cycle", 64'(cyc), 64'(exp_tmo_q.pop_front()));
            end
        end
    end

    // driver tasks (start and end on a negedge)
    int          last_drive_cyc;
    logic [15:0] pay [256];

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        in_data        = w;
        in_request     = 1'b1;
        last_drive_cyc = cyc;
        @(negedge clk);
        in_request     = 1'b0;
    endtask

    task automatic gap(input bit gaps);
        if (gaps) idle($urandom_range(0, 2));
    endtask

    task automatic send_pkt(input logic [15:0] addr_w, input logic [7:0] sz, input logic [7:0] c,
                            input logic [15:0] sum_w, input logic [15:0] num_w, input bit gaps);
        bit          hit;
        logic [15:0] model_sum;
        hit       = (addr_w[15:8] == 8'hAB) || (addr_w[15:8] == 8'hAC);
        model_sum = addr_w + {sz, c};
        send_word(addr_w); gap(gaps);
        if (hit) exp_hdr_q.push_back({addr_w[15:8] == 8'hAC, c, sz});
        send_word({sz, c}); gap(gaps);
        for (int i = 0; i < int'(sz); i++) begin
            model_sum = model_sum + pay[i];
            if (hit) exp_out_q.push_back({32'(cyc + 1), pay[i]});
            send_word(pay[i]); gap(gaps);
        end
        send_word(sum_w); gap(gaps);
        if (hit) exp_done_q.push_back({sum_w == model_sum, num_w});
        send_word(num_w); gap(gaps);
    endtask

    task automatic load_vec1();
        pay[0] = 16'hFFA1; pay[1] = 16'h0001; pay[2] = 16'h0002;
        pay[3] = 16'hAB45; pay[4] = 16'hFFA3; pay[5] = 16'hFFA1;
    endtask

    function automatic logic [15:0] good_sum(input logic [15:0] a, input logic [7:0] sz, input logic [7:0] c);
        logic [15:0] s;
        s = a + {sz, c};
        for (int i = 0; i < int'(sz); i++) s = s + pay[i];
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        nRst       = 1'b0;
        in_data    = 16'h0000;
        in_request = 1'b0;
        idle(3);
        check("reset_outputs", {9'b0, out_data, out_valid, hdr_valid, addr_sel, cmd, size,
                                pkt_done, pkt_ok, pkt_num, timeout_err, busy}, 64'd0);
        nRst = 1'b1;
        idle(2);

        // reference packet, back-to-back words
        load_vec1();
        send_pkt(16'hAB00, 8'h06, 8'hA2, 16'h5BCF, 16'h0000, 1'b0);
        idle(2);

        // leading fillers, second address, ten zero data words
        repeat (3) send_word(16'h0000);
        for (int i = 0; i < 10; i++) pay[i] = 16'h0000;
        send_pkt(16'hAC00, 8'h0A, 8'hB0, 16'hB6B0, 16'h0000, 1'b1);
        check("busy_after_pkt", {63'b0, busy}, 64'd0);

        // bad checksum
        load_vec1();
        send_pkt(16'hAB00, 8'h06, 8'hA2, 16'h5BCE, 16'h0000, 1'b0);

        // foreign address whose payload looks like a valid header
        pay[0] = 16'hAB00; pay[1] = 16'h06A2;
        send_pkt(16'hAD00, 8'h02, 8'hA2, 16'h1234, 16'h0000, 1'b0);
        load_vec1();
        send_pkt(16'hAB00, 8'h06, 8'hA2, 16'h5BCF, 16'h0007, 1'b0);

        // size zero goes straight to the checksum word
        send_pkt(16'hAB7E, 8'h00, 8'h11, 16'hAB8F, 16'h1234, 1'b0);

        // randomized packets, good and corrupted sums
        for (int p = 0; p < 8; p++) begin
            logic [15:0] a;
            logic [7:0]  sz, c;
            logic [15:0] s;
            a  = {($urandom_range(0, 1) != 0) ? 8'hAC : 8'hAB, 8'($urandom)};
            sz = 8'($urandom_range(0, 20));
            c  = 8'($urandom);
            for (int i = 0; i < int'(sz); i++) pay[i] = 16'($urandom);
            s = good_sum(a, sz, c);
            if ($urandom_range(0, 3) == 0) s = s ^ 16'h0100;
            send_pkt(a, sz, c, s, 16'($urandom), 1'b1);
        end

        // size FF: skipped foreign packet must not wrap, then a full valid one
        for (int i = 0; i < 255; i++) pay[i] = 16'($urandom);
        pay[0] = 16'hAB00;
        send_pkt(16'hAD12, 8'hFF, 8'h33, 16'h5555, 16'hAC00, 1'b0);
        send_pkt(16'hAC01, 8'hFF, 8'h44, good_sum(16'hAC01, 8'hFF, 8'h44), 16'hBEEF, 1'b0);

        // word arriving on the last allowed idle cycle is accepted
        exp_hdr_q.push_back({1'b0, 8'hA2, 8'h01});
        send_word(16'hAB00);
        send_word(16'h01A2);
        idle(int'(TIMEOUT) - 1);
        exp_out_q.push_back({32'(cyc + 1), 16'h4242});
        send_word(16'h4242);
        exp_done_q.push_back({1'b1, 16'h0055});
        send_word(16'hAB00 + 16'h01A2 + 16'h4242);
        send_word(16'h0055);
        check("no_tmo_on_edge", 64'(exp_tmo_q.size()), 64'd0);

        // timeout expiry after a partial packet
        exp_hdr_q.push_back({1'b0, 8'hA2, 8'h06});
        send_word(16'hAB00);
        send_word(16'h06A2);
        exp_out_q.push_back({32'(cyc + 1), 16'h0001});
        send_word(16'h0001);
        exp_tmo_q.push_back(last_drive_cyc + 1 + int'(TIMEOUT));
        idle(int'(TIMEOUT) - 1);
        check("busy_before_tmo", {63'b0, busy}, 64'd1);
        idle(2);
        check("busy_after_tmo", {63'b0, busy}, 64'd0);
        check("tmo_seen", 64'(exp_tmo_q.size()), 64'd0);
        load_vec1();
        send_pkt(16'hAB00, 8'h06, 8'hA2, 16'h5BCF, 16'h0000, 1'b0);

        // reset in the middle of the data phase
        load_vec1();
        exp_hdr_q.push_back({1'b0, 8'hA2, 8'h06});
        send_word(16'hAB00);
        send_word(16'h06A2);
        for (int i = 0; i < 3; i++) begin
            exp_out_q.push_back({32'(cyc + 1), pay[i]});
            send_word(pay[i]);
        end
        #2 nRst = 1'b0;
        #1 check("mid_reset_outputs", {9'b0, out_data, out_valid, hdr_valid, addr_sel, cmd, size,
                                       pkt_done, pkt_ok, pkt_num, timeout_err, busy}, 64'd0);
        idle(3);
        nRst = 1'b1;
        idle(20);
        send_pkt(16'hAC00, 8'h06, 8'hA2, good_sum(16'hAC00, 8'h06, 8'hA2), 16'h0099, 1'b1);

        idle(5);
        check("out_q_drained",  64'(exp_out_q.size()),  64'd0);
        check("hdr_q_drained",  64'(exp_hdr_q.size()),  64'd0);
        check("done_q_drained", 64'(exp_done_q.size()), 64'd0);
        check("tmo_q_drained",  64'(exp_tmo_q.size()),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
